// File: rtl/cp0_pkg.sv
// CP0 register numbers and interrupt-line layout.
// The CP0 block and the interrupt-source stage both use these constants.
package cp0_pkg;

    localparam int CP0_INT_W      = 6;
    localparam int CP0_EXT_W      = 5;
    localparam int CP0_TIMER_LINE = 5;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_IRQCLR  = 5'd22;

    typedef logic [CP0_INT_W-1:0] cp0_int_t;

endpackage

// File: rtl/irq_sync.sv
// One external interrupt line: synchroniser chain, then a level follower or a rising-edge pending flop.
// A stable rising input reaches irq after SYNC_STAGES+1 edges in either mode.
module irq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic clr,
    output logic irq
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_irq;
    logic                   w_sync;
    logic                   w_rise;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_prev;
    assign irq    = r_irq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= w_sync;
            // A new edge on the same cycle as a software clear must not be lost.
            if (EDGE) begin
                r_irq <= w_rise | (r_irq & ~clr);
            end else begin
                r_irq <= w_sync;
            end
        end
    end

endmodule

// File: rtl/cp0_irq_source.sv
// Interrupt sources for CP0: five synchronised external lines plus the Count/Compare timer on line 5.
// int_ is registered; mfc0 read data is combinational from current register state.
module cp0_irq_source
    import cp0_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter int               COUNT_DIV   = 2,
    parameter logic [CP0_EXT_W-1:0] EXT_EDGE = 5'b00000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CP0_EXT_W-1:0] ext_irq,
    input  logic                 we,
    input  logic [4:0]           r_reg,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    output logic [CP0_INT_W-1:0] int_
);

    localparam int            PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]          r_count;
    logic [31:0]          r_compare;
    logic [PW-1:0]        r_presc;
    logic                 r_tpend;

    logic                 w_tick;
    logic                 w_wr_count;
    logic                 w_wr_compare;
    logic                 w_wr_irqclr;
    logic [31:0]          w_count_inc;
    logic [CP0_EXT_W-1:0] w_ext_irq;

    assign w_tick       = (r_presc == PRESC_MAX);
    assign w_wr_count   = we && (r_reg == CP0_COUNT);
    assign w_wr_compare = we && (r_reg == CP0_COMPARE);
    assign w_wr_irqclr  = we && (r_reg == CP0_IRQCLR);
    assign w_count_inc  = r_count + 32'd1;

    for (genvar gi = 0; gi < CP0_EXT_W; gi++) begin : g_ext
        irq_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EXT_EDGE[gi])
        ) u_irq_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (ext_irq[gi]),
            .clr      (w_wr_irqclr & data_in[gi]),
            .irq      (w_ext_irq[gi])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_presc   <= '0;
            r_tpend   <= 1'b0;
        end else begin
            // Loading Count restarts the prescaler so the next increment is a full period away.
            if (w_wr_count) begin
                r_count <= data_in;
                r_presc <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    r_count <= w_count_inc;
                end
            end

            if (w_wr_compare) begin
                r_compare <= data_in;
            end

            if (w_wr_compare) begin
                r_tpend <= 1'b0;
            end else if (w_tick && !w_wr_count && (w_count_inc == r_compare)) begin
                r_tpend <= 1'b1;
            end
        end
    end

    assign int_[CP0_TIMER_LINE]     = r_tpend;
    assign int_[CP0_EXT_W-1:0]      = w_ext_irq;

    always_comb begin
        data_out = 32'd0;
        case (r_reg)
            CP0_COUNT:   data_out = r_count;
            CP0_COMPARE: data_out = r_compare;
            CP0_IRQCLR:  data_out = {{(32-CP0_INT_W){1'b0}}, int_};
            default:     data_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_source.sv
// Bench for cp0_irq_source: directed table, hand sequences and random traffic against a history-based model.
module tb_cp0_irq_source;

    localparam int         S    = 2;
    localparam int         DIV  = 2;
    localparam logic [4:0] EDGE = 5'b11010;

    logic        clk;
    logic        rst;
    logic [4:0]  ext_irq;
    logic        we;
    logic [4:0]  r_reg;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [5:0]  int_;

    int n_chk;
    int n_err;

    cp0_irq_source #(
        .SYNC_STAGES (S),
        .COUNT_DIV   (DIV),
        .EXT_EDGE    (EDGE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ext_irq  (ext_irq),
        .we       (we),
        .r_reg    (r_reg),
        .data_in  (data_in),
        .data_out (data_out),
        .int_     (int_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: Count is base + (edges since load) / DIV; external lines come from input history.
    logic [31:0]  m_base;
    int unsigned  m_since;
    logic [31:0]  m_compare;
    logic         m_tpend;
    logic [4:0]   m_epend;
    logic [4:0]   hist[$];

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_since / DIV);
    endfunction

    function automatic logic [5:0] m_int();
        return {m_tpend, m_epend};
    endfunction

    function automatic logic [31:0] m_dout(input logic [4:0] rg);
        if (rg == 5'd9)  return m_count();
        if (rg == 5'd11) return m_compare;
        if (rg == 5'd22) return {26'd0, m_int()};
        return 32'd0;
    endfunction

    function automatic logic [4:0] hist_back(input int k);
        if (hist.size() > k) return hist[hist.size()-1-k];
        return 5'b0;
    endfunction

    task automatic model_reset();
        m_base    = '0;
        m_since   = 0;
        m_compare = '0;
        m_tpend   = 1'b0;
        m_epend   = '0;
        hist.delete();
    endtask

    task automatic model_edge(input logic w, input logic [4:0] rg, input logic [31:0] d, input logic [4:0] x);
        logic [4:0]  s_now, s_old, clr;
        logic [31:0] old_cnt, new_cnt;
        logic        cw;
        hist.push_back(x);
        if (hist.size() > 8) void'(hist.pop_front());
        s_now = hist_back(S);
        s_old = hist_back(S + 1);
        clr   = (w && rg == 5'd22) ? d[4:0] : 5'b0;
        for (int i = 0; i < 5; i++) begin
            if (EDGE[i]) m_epend[i] = (s_now[i] & ~s_old[i]) | (m_epend[i] & ~clr[i]);
            else         m_epend[i] = s_now[i];
        end
        old_cnt = m_count();
        cw = w && rg == 5'd9;
        if (cw) begin
            m_base  = d;
            m_since = 0;
        end else begin
            m_since++;
        end
        new_cnt = m_count();
        if (w && rg == 5'd11) begin
            m_compare = d;
            m_tpend   = 1'b0;
        end else if (!cw && new_cnt != old_cnt && new_cnt == m_compare) begin
            m_tpend = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs in the low phase, apply the edge, compare after the falling edge.
    task automatic step(input logic w, input logic [4:0] rg, input logic [31:0] d, input logic [4:0] x);
        we = w; r_reg = rg; data_in = d; ext_irq = x;
        #1 chk("read_pre", data_out, m_dout(rg));
        @(posedge clk);
        model_edge(w, rg, d, x);
        @(negedge clk);
        chk("int_", {26'd0, int_}, {26'd0, m_int()});
    endtask

    task automatic reset_phase(input int cyc);
        #2 rst = 1'b0;
        model_reset();
        for (int c = 0; c < cyc; c++) begin
            we = 1'b1; data_in = $urandom; ext_irq = 5'($urandom);
            #1 chk("rst_int", {26'd0, int_}, 32'd0);
            r_reg = 5'd9;  #1 chk("rst_rd9", data_out, 32'd0);
            r_reg = 5'd11; #1 chk("rst_rd11", data_out, 32'd0);
            r_reg = 5'd22; @(negedge clk);
            chk("rst_rd22", data_out, 32'd0);
        end
        we = 1'b0; ext_irq = 5'b0; r_reg = 5'd9; data_in = '0;
        #2 rst = 1'b1;
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  rg;
        logic [31:0] d;
        logic [31:0] exp_pre;
        logic [5:0]  exp_int;
    } vec_t;

    vec_t vecs[19];

    initial begin
        logic [4:0] x;
        int         r;
        n_chk = 0; n_err = 0;
        rst = 1'b0; we = 1'b0; r_reg = '0; data_in = '0; ext_irq = '0;
        model_reset();

        vecs[0]  = '{1'b1, 5'd11, 32'd5,     32'd5 - 32'd5, 6'h00};
        vecs[1]  = '{1'b1, 5'd9,  32'd3,     32'd0,     6'h00};
        vecs[2]  = '{1'b0, 5'd9,  32'd0,     32'd3,     6'h00};
        vecs[3]  = '{1'b0, 5'd9,  32'd0,     32'd3,     6'h00};
        vecs[4]  = '{1'b0, 5'd9,  32'd0,     32'd4,     6'h00};
        vecs[5]  = '{1'b0, 5'd9,  32'd0,     32'd4,     6'h20};
        vecs[6]  = '{1'b1, 5'd11, 32'd7,     32'd5,     6'h00};
        vecs[7]  = '{1'b1, 5'd9,  32'd7,     32'd5,     6'h00};
        vecs[8]  = '{1'b0, 5'd9,  32'd0,     32'd7,     6'h00};
        vecs[9]  = '{1'b0, 5'd22, 32'd0,     32'd0,     6'h00};
        vecs[10] = '{1'b1, 5'd11, 32'd9,     32'd7,     6'h00};
        vecs[11] = '{1'b0, 5'd9,  32'd0,     32'd8,     6'h20};
        vecs[12] = '{1'b1, 5'd11, 32'd10,    32'd9,     6'h00};
        vecs[13] = '{1'b1, 5'd11, 32'h30,    32'd10,    6'h00};
        vecs[14] = '{1'b0, 5'd9,  32'd0,     32'd10,    6'h00};
        vecs[15] = '{1'b1, 5'd9,  32'h100,   32'd10,    6'h00};
        vecs[16] = '{1'b0, 5'd9,  32'd0,     32'h100,   6'h00};
        vecs[17] = '{1'b0, 5'd9,  32'd0,     32'h100,   6'h00};
        vecs[18] = '{1'b0, 5'd9,  32'd0,     32'h101,   6'h00};

        @(negedge clk);
        reset_phase(3);

        // Count starts at 0 and first increments two edges after reset release.
        step(1'b0, 5'd9, 32'd0, 5'b0);
        chk("cnt_after1", data_out, 32'd0);
        step(1'b0, 5'd9, 32'd0, 5'b0);
        chk("cnt_after2", data_out, 32'd1);

        // Directed timer table from a fresh reset.
        reset_phase(1);
        for (int i = 0; i < 19; i++) begin
            we = 1'b0; r_reg = vecs[i].rg;
            #1 chk($sformatf("tbl%0d_rd", i), data_out, vecs[i].exp_pre);
            step(vecs[i].w, vecs[i].rg, vecs[i].d, 5'b0);
            chk($sformatf("tbl%0d_int", i), {26'd0, int_}, {26'd0, vecs[i].exp_int});
        end

        // Level line 0: three edges to assert, W1C ignored, three edges to release.
        step(1'b0, 5'd9, 32'd0, 5'b00001); chk("lvl_r1", {31'd0, int_[0]}, 32'd0);
        step(1'b0, 5'd9, 32'd0, 5'b00001); chk("lvl_r2", {31'd0, int_[0]}, 32'd0);
        step(1'b0, 5'd9, 32'd0, 5'b00001); chk("lvl_r3", {31'd0, int_[0]}, 32'd1);
        step(1'b1, 5'd22, 32'd1, 5'b00001); chk("lvl_w1c", {31'd0, int_[0]}, 32'd1);
        step(1'b0, 5'd9, 32'd0, 5'b00000); chk("lvl_f1", {31'd0, int_[0]}, 32'd1);
        step(1'b0, 5'd9, 32'd0, 5'b00000); chk("lvl_f2", {31'd0, int_[0]}, 32'd1);
        step(1'b0, 5'd9, 32'd0, 5'b00000); chk("lvl_f3", {31'd0, int_[0]}, 32'd0);

        // Edge line 1: latch a short pulse, clear it, then collide a new edge with a clear.
        step(1'b0, 5'd9, 32'd0, 5'b00010); chk("edg_p1", {31'd0, int_[1]}, 32'd0);
        step(1'b0, 5'd9, 32'd0, 5'b00010); chk("edg_p2", {31'd0, int_[1]}, 32'd0);
        step(1'b0, 5'd9, 32'd0, 5'b00000); chk("edg_set", {31'd0, int_[1]}, 32'd1);
        step(1'b0, 5'd9, 32'd0, 5'b00000); chk("edg_hold", {31'd0, int_[1]}, 32'd1);
        step(1'b1, 5'd22, 32'd2, 5'b00000); chk("edg_clr", {31'd0, int_[1]}, 32'd0);
        step(1'b0, 5'd9, 32'd0, 5'b00010);
        step(1'b0, 5'd9, 32'd0, 5'b00010);
        step(1'b1, 5'd22, 32'd2, 5'b00000); chk("edg_setwins", {31'd0, int_[1]}, 32'd1);
        step(1'b1, 5'd22, 32'd2, 5'b00000); chk("edg_clr2", {31'd0, int_[1]}, 32'd0);

        // Count wraps through 0xFFFFFFFF to 0 and matches Compare=0 there.
        step(1'b1, 5'd11, 32'd0, 5'b0);
        step(1'b1, 5'd9, 32'hFFFF_FFFE, 5'b0);
        step(1'b0, 5'd9, 32'd0, 5'b0);
        step(1'b0, 5'd9, 32'd0, 5'b0);
        chk("wrap_max", data_out, 32'hFFFF_FFFF);
        chk("wrap_nopend", {31'd0, int_[5]}, 32'd0);
        step(1'b0, 5'd9, 32'd0, 5'b0);
        step(1'b0, 5'd9, 32'd0, 5'b0);
        chk("wrap_zero", data_out, 32'd0);
        chk("wrap_pend", {31'd0, int_[5]}, 32'd1);

        // Random traffic, including a reset in the middle of activity.
        x = 5'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) reset_phase(2);
            x = x ^ (5'($urandom) & 5'($urandom));
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    step(1'b1, 5'd9, m_compare - 32'($urandom_range(0, 4)), x);
                2, 3:    step(1'b1, 5'd11, m_count() + 32'($urandom_range(0, 5)), x);
                4:       step(1'b1, 5'd22, $urandom, x);
                5:       step(1'b1, 5'($urandom), $urandom, x);
                6, 7:    step(1'b0, 5'd22, $urandom, x);
                8:       step(1'b0, 5'd11, $urandom, x);
                9:       step(1'b0, 5'($urandom), $urandom, x);
                default: step(1'b0, 5'd9, $urandom, x);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
